// File: rtl/cv32e41p_apu_wb_buffer.sv
// cv32e41p_apu_wb_buffer
// In-order writeback buffer that sits between the APU result channel and the
// register-file APU write port. Results wait in a small circular FIFO until
// the core grants the shared write port. The pending destination addresses
// are exposed for hazard detection.
// Optional feature macro: CV32E41P_APU_WB_BYPASS_EN. When it is defined, a
// result that arrives while the FIFO is empty and the port is granted skips
// the FIFO and goes straight to the output register.
module cv32e41p_apu_wb_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         apu_rvalid_i,
  input  logic [5:0]                   apu_waddr_i,
  input  logic [31:0]                  apu_result_i,
  output logic                         apu_rready_o,
  input  logic                         wb_grant_i,
  output logic                         apu_valid_o,
  output logic [5:0]                   apu_waddr_o,
  output logic [31:0]                  apu_result_o,
  input  logic [5:0]                   chk_addr_i,
  output logic                         chk_hit_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [5:0]  waddr;
    logic [31:0] result;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [5:0]         waddr_q, waddr_d;
  logic [31:0]        result_q, result_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               bypass;
  logic [PTR_W-1:0]   hit_offset;

  // Handshake decode: full/empty flags, accept, pop and optional bypass.
  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    empty        = (count_q == '0);
    // A pop in the same cycle does not open a slot: ready looks only at count.
    apu_rready_o = !rst_i && !full;
    pop          = !empty && wb_grant_i;
`ifdef CV32E41P_APU_WB_BYPASS_EN
    bypass       = empty && apu_rvalid_i && wb_grant_i;
`else
    bypass       = 1'b0;
`endif
    // A bypassed result never enters the FIFO.
    push         = apu_rvalid_i && apu_rready_o && !bypass;
  end

  // Next-state for FIFO storage, pointers, count and the output stage.
  always_comb begin
    // NOTE: every variable gets its hold value first so that no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = pop || bypass;
    waddr_d  = waddr_q;
    result_d = result_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{waddr: apu_waddr_i, result: apu_result_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      waddr_d  = mem_q[rd_ptr_q].waddr;
      result_d = mem_q[rd_ptr_q].result;
    end else if (bypass) begin
      waddr_d  = apu_waddr_i;
      result_d = apu_result_i;
    end
  end

  // Control and output-stage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      waddr_q  <= '0;
      result_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      waddr_q  <= waddr_d;
      result_q <= result_d;
    end
  end

  // FIFO storage registers.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; an entry is only meaningful
    // while count/pointers mark it valid, so resetting it buys nothing.
    mem_q <= mem_d;
  end

  // Pending-write lookup over valid FIFO entries and the output stage.
  always_comb begin
    hit_offset = '0;
    chk_hit_o  = valid_q && (waddr_q == chk_addr_i);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Distance of slot i from the head; valid when it is below count.
      hit_offset = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(hit_offset) < count_q) && (mem_q[i].waddr == chk_addr_i)) begin
        chk_hit_o = 1'b1;
      end
    end
  end

  assign apu_valid_o  = valid_q;
  assign apu_waddr_o  = waddr_q;
  assign apu_result_o = result_q;
  assign count_o      = count_q;

endmodule
